// File: rtl/amux_seq_ctrl.sv
// amux_seq_ctrl -- sequencer for a bank of N_CH analog mux inputs.
//
// Drives registered one-hot switch selects with break-before-make dead time
// (BBM_CYC cycles with every switch open), waits a programmable settle
// delay, then presents the settled channel to the ADC with a
// sample_valid / sample_ack handshake. Operates either on manual
// single-channel requests or as a masked round-robin auto-scan.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   mode                 0 = manual, 1 = auto-scan
//   ch_req/_valid/_ready manual channel request handshake
//   scan_mask            channel enables for auto-scan
//   settle_cyc           settle cycles after the switch closes
//   sel_onehot           registered switch selects (all-zero = open)
//   ch_cur               channel being / last selected
//   sample_valid/_ack    ADC handshake for a settled channel
//   req_err              one-cycle pulse on an out-of-range manual request
//   busy                 high whenever the sequencer is not idle
module amux_seq_ctrl #(
  parameter int N_CH     = 8,
  parameter int SEL_W    = 3,
  parameter int BBM_CYC  = 2,
  parameter int SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                mode,
  input  logic [SEL_W-1:0]    ch_req,
  input  logic                ch_req_valid,
  output logic                ch_req_ready,
  input  logic [N_CH-1:0]     scan_mask,
  input  logic [SETTLE_W-1:0] settle_cyc,
  output logic [N_CH-1:0]     sel_onehot,
  output logic [SEL_W-1:0]    ch_cur,
  output logic                sample_valid,
  input  logic                sample_ack,
  output logic                req_err,
  output logic                busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BREAK  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_VALID  = 2'd3;

  // One down-counter serves both the dead-time and the settle phases.
  localparam int BBM_W = $clog2(BBM_CYC + 1);
  localparam int CNT_W = (SETTLE_W > BBM_W) ? SETTLE_W : BBM_W;
  localparam logic [CNT_W-1:0] BBM_LD = CNT_W'(BBM_CYC);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [SEL_W-1:0] first_ch;
  logic [SEL_W-1:0] next_ch;

  // Lowest enabled channel, and the round-robin successor of ch_q.
  // Descending loops let the closest candidate be the last (winning) write;
  // k = N_CH revisits the current channel so it is picked only as a last resort.
  always_comb begin
    first_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (scan_mask[i]) first_ch = SEL_W'(i);
    next_ch = ch_q;
    for (int k = N_CH; k >= 1; k--) begin
      int idx;
      idx = (int'(ch_q) + k) % N_CH;
      if (scan_mask[idx]) next_ch = SEL_W'(idx);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ch_req_valid && ch_req_ready) begin
          if (int'(ch_req) >= N_CH) begin
            err_d = 1'b1;
          end else begin
            ch_d    = ch_req;
            cnt_d   = BBM_LD;
            state_d = S_BREAK;
          end
        end else if (mode && (|scan_mask)) begin
          ch_d    = first_ch;
          cnt_d   = BBM_LD;
          state_d = S_BREAK;
        end
      end
      S_BREAK: begin
        // The old switch stays closed through the accept edge and opens on
        // the first BREAK edge, so exactly BBM_CYC cycles see all-open.
        sel_d = '0;
        if (cnt_q == '0) begin
          sel_d[ch_q] = 1'b1;
          cnt_d       = CNT_W'(settle_cyc);
          state_d     = S_SETTLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          valid_d = 1'b1;
          state_d = S_VALID;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_VALID: begin
        if (sample_ack) begin
          valid_d = 1'b0;
          if (!mode) begin
            state_d = S_IDLE;              // manual: leave channel connected
          end else if (|scan_mask) begin
            ch_d    = next_ch;
            cnt_d   = BBM_LD;
            state_d = S_BREAK;
          end else begin
            sel_d   = '0;                  // scan with nothing enabled: open all
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign ch_req_ready = (state_q == S_IDLE) && !mode;
  assign busy         = (state_q != S_IDLE);
  assign sel_onehot   = sel_q;
  assign ch_cur       = ch_q;
  assign sample_valid = valid_q;
  assign req_err      = err_q;

endmodule
